// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Purpose  : Shared definitions for the multicycle RV32I control path.
//            Opcode constants, the immediate-format encoding used by the
//            immediate generator, ALU operation selects and the controller
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    // Major opcodes (instruction bits [6:0]) handled by the controller
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    // Immediate format; this encoding is also decoded by the immediate generator
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_e;

    // ALU operation selects
    localparam logic [1:0] c_ALU_ADD   = 2'b00;  // address calculation
    localparam logic [1:0] c_ALU_CMP   = 2'b01;  // branch compare
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;  // decoded from funct3/funct7

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    // Immediate format implied by an opcode; unsupported opcodes give NONE
    function automatic imm_sel_e imm_sel_of(input logic [6:0] opc);
        imm_sel_e r;
        r = IMM_NONE;
        case (opc)
            c_OPC_LOAD,
            c_OPC_OP_IMM: r = IMM_I;
            c_OPC_STORE:  r = IMM_S;
            c_OPC_BRANCH: r = IMM_B;
            default:      r = IMM_NONE;
        endcase
        return r;
    endfunction

    // True for every opcode the controller can sequence
    function automatic logic opc_supported(input logic [6:0] opc);
        return (opc == c_OPC_LOAD)   || (opc == c_OPC_STORE) ||
               (opc == c_OPC_BRANCH) || (opc == c_OPC_OP_IMM) ||
               (opc == c_OPC_OP);
    endfunction

endpackage : rv_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM of the multicycle RV32I core. Sequences
//            fetch / decode / execute / memory / writeback over a single
//            shared instruction+data memory port and counts retired
//            instructions.
// Ports    :
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   mem_ack_i      in   memory completion (only looked at while requesting)
//   mem_rdata_op_i in   read data bits [6:0], captured on fetch ack
//   branch_taken_i in   ALU compare result, used in EXEC for branches
//   mem_req_o      out  memory request
//   mem_we_o       out  1 = write, 0 = read
//   addr_sel_o     out  memory address: 0 = PC, 1 = ALU result
//   ir_we_o        out  instruction register load
//   mdr_we_o       out  memory data register load
//   imm_sel_o      out  immediate format (rv_ctrl_pkg::imm_sel_e)
//   alu_src_o      out  ALU operand B: 0 = rs2, 1 = immediate
//   alu_op_o       out  ALU operation select
//   reg_we_o       out  register-file write enable
//   wb_sel_o       out  writeback source: 0 = ALU, 1 = MDR
//   pc_we_o        out  PC write enable
//   pc_sel_o       out  next PC: 0 = PC+4, 1 = branch target
//   instret_o      out  retired-instruction count (wraps silently)
//   illegal_o      out  sticky unsupported-opcode flag
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_ack_i,
    input  logic [6:0]       mem_rdata_op_i,
    input  logic             branch_taken_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             addr_sel_o,
    output logic             ir_we_o,
    output logic             mdr_we_o,
    output logic [1:0]       imm_sel_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_we_o,
    output logic             wb_sel_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o
);

    state_e           r_state;
    state_e           w_next;
    logic [6:0]       r_opcode;
    logic [CNT_W-1:0] r_instret;
    logic             w_opc_load;
    logic             w_retire;
    imm_sel_e         w_imm;
    logic             w_is_load;
    logic             w_is_store;

    assign w_is_load  = (r_opcode == c_OPC_LOAD);
    assign w_is_store = (r_opcode == c_OPC_STORE);

    // ------------------------------------------------------------------
    // State, opcode and retire-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_opcode  <= 7'd0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_opc_load) begin
                r_opcode <= mem_rdata_op_i;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Outputs depend on state and latched opcode;
    // only the ack-qualified strobes and the retire look at mem_ack_i, so
    // the request/address signals stay stable across wait cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_opc_load  = 1'b0;
        w_retire    = 1'b0;
        w_imm       = IMM_NONE;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_we_o     = 1'b0;
        mdr_we_o    = 1'b0;
        alu_src_o   = 1'b0;
        alu_op_o    = c_ALU_ADD;
        reg_we_o    = 1'b0;
        wb_sel_o    = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        illegal_o   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_we_o    = 1'b1;
                    w_opc_load = 1'b1;
                    w_next     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_imm  = imm_sel_of(r_opcode);
                w_next = opc_supported(r_opcode) ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                w_imm = imm_sel_of(r_opcode);
                case (r_opcode)
                    c_OPC_LOAD,
                    c_OPC_STORE: begin
                        alu_src_o = 1'b1;
                        alu_op_o  = c_ALU_ADD;
                        w_next    = ST_MEM;
                    end
                    c_OPC_OP_IMM: begin
                        alu_src_o = 1'b1;
                        alu_op_o  = c_ALU_FUNCT;
                        w_next    = ST_WB;
                    end
                    c_OPC_OP: begin
                        alu_src_o = 1'b0;
                        alu_op_o  = c_ALU_FUNCT;
                        w_next    = ST_WB;
                    end
                    c_OPC_BRANCH: begin
                        // Branch resolves and retires here: 3-cycle instruction
                        alu_src_o = 1'b0;
                        alu_op_o  = c_ALU_CMP;
                        pc_we_o   = 1'b1;
                        pc_sel_o  = branch_taken_i;
                        w_retire  = 1'b1;
                        w_next    = ST_FETCH;
                    end
                    default: begin
                        // Unreachable: DECODE filters unsupported opcodes
                        w_next = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = w_is_store;
                if (mem_ack_i) begin
                    if (w_is_store) begin
                        pc_we_o  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        mdr_we_o = 1'b1;
                        w_next   = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_we_o = 1'b1;
                wb_sel_o = w_is_load;
                pc_we_o  = 1'b1;
                w_retire = 1'b1;
                w_next   = ST_FETCH;
            end

            ST_TRAP: begin
                illegal_o = 1'b1;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign imm_sel_o = w_imm;
    assign instret_o = r_instret;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. Instruction records
//            from a table are expanded into per-cycle stimulus with the
//            expected output bundle; expectations are queued as each cycle
//            is driven and compared when the DUT outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_BAD    = 7'b1111111;

    logic             clk;
    logic             rst_n;
    logic             mem_ack_i;
    logic [6:0]       mem_rdata_op_i;
    logic             branch_taken_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             addr_sel_o;
    logic             ir_we_o;
    logic             mdr_we_o;
    logic [1:0]       imm_sel_o;
    logic             alu_src_o;
    logic [1:0]       alu_op_o;
    logic             reg_we_o;
    logic             wb_sel_o;
    logic             pc_we_o;
    logic             pc_sel_o;
    logic [CNT_W-1:0] instret_o;
    logic             illegal_o;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_op_i (mem_rdata_op_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .addr_sel_o     (addr_sel_o),
        .ir_we_o        (ir_we_o),
        .mdr_we_o       (mdr_we_o),
        .imm_sel_o      (imm_sel_o),
        .alu_src_o      (alu_src_o),
        .alu_op_o       (alu_op_o),
        .reg_we_o       (reg_we_o),
        .wb_sel_o       (wb_sel_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .instret_o      (instret_o),
        .illegal_o      (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle in a fixed order:
    // {req, we, asel, ir_we, mdr_we, imm[1:0], src, aop[1:0], reg_we, wb_sel, pc_we, pc_sel, illegal}
    logic [14:0] w_act;
    assign w_act = {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, mdr_we_o, imm_sel_o,
                    alu_src_o, alu_op_o, reg_we_o, wb_sel_o, pc_we_o, pc_sel_o, illegal_o};

    typedef struct {
        logic        ack;
        logic [6:0]  rdata;
        logic        taken;
        logic [14:0] exp;
        logic [3:0]  cnt;
    } cyc_t;

    typedef struct {
        logic [6:0] opc;
        int         fw;     // fetch wait cycles
        int         mw;     // memory wait cycles
        logic       taken;
    } instr_t;

    cyc_t       plan_q[$];
    cyc_t       sb_q[$];
    logic [3:0] m_cnt;
    int         n_pass;
    int         n_total;
    int         cyc_idx;

    function automatic logic [14:0] mk(input logic req, input logic we, input logic asel,
                                        input logic irwe, input logic mdrwe,
                                        input logic [1:0] imm, input logic src,
                                        input logic [1:0] aop, input logic regwe,
                                        input logic wbs, input logic pcwe,
                                        input logic pcs, input logic ill);
        return {req, we, asel, irwe, mdrwe, imm, src, aop, regwe, wbs, pcwe, pcs, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One planned cycle; ret marks the cycle in which an instruction retires
    task automatic push(input logic ack, input logic [6:0] rd, input logic tk,
                        input logic [14:0] e, input logic ret);
        cyc_t c;
        c.ack   = ack;
        c.rdata = rd;
        c.taken = tk;
        c.exp   = e;
        c.cnt   = m_cnt;
        plan_q.push_back(c);
        if (ret) m_cnt = m_cnt + 4'd1;
    endtask

    // Cycle in a state without a memory request: ack/data are random noise
    task automatic push_idle_like(input logic [14:0] e, input logic ret);
        push(1'($urandom), 7'($urandom), 1'($urandom), e, ret);
    endtask

    // Expand one instruction into its expected cycle sequence. With abort=1
    // only mw un-acked MEM cycles are planned (the access is left hanging).
    task automatic add_instr(input logic [6:0] opc, input int fw, input int mw,
                             input logic tk, input logic abort);
        logic [1:0] imm;
        logic       legal;
        logic       ld;
        logic       st;
        int         n;
        ld    = (opc == c_LOAD);
        st    = (opc == c_STORE);
        legal = 1'b1;
        case (opc)
            c_LOAD, c_OPIMM: imm = 2'd1;
            c_STORE:         imm = 2'd2;
            c_BRANCH:        imm = 2'd3;
            c_OP:            imm = 2'd0;
            default: begin
                imm   = 2'd0;
                legal = 1'b0;
            end
        endcase
        // FETCH
        for (int i = 0; i <= fw; i++) begin
            logic last;
            last = (i == fw);
            push(last, last ? opc : 7'($urandom), 1'($urandom),
                 mk(1, 0, 0, last, 0, 2'd0, 0, 2'b00, 0, 0, 0, 0, 0), 0);
        end
        // DECODE
        push_idle_like(mk(0, 0, 0, 0, 0, imm, 0, 2'b00, 0, 0, 0, 0, 0), 0);
        if (!legal) return;
        // EXEC
        if (opc == c_BRANCH) begin
            push(1'($urandom), 7'($urandom), tk,
                 mk(0, 0, 0, 0, 0, imm, 0, 2'b01, 0, 0, 1, tk, 0), 1);
            return;
        end
        if (ld || st)
            push_idle_like(mk(0, 0, 0, 0, 0, imm, 1, 2'b00, 0, 0, 0, 0, 0), 0);
        else if (opc == c_OPIMM)
            push_idle_like(mk(0, 0, 0, 0, 0, imm, 1, 2'b10, 0, 0, 0, 0, 0), 0);
        else
            push_idle_like(mk(0, 0, 0, 0, 0, imm, 0, 2'b10, 0, 0, 0, 0, 0), 0);
        // MEM
        if (ld || st) begin
            n = abort ? mw : mw + 1;
            for (int i = 0; i < n; i++) begin
                logic last;
                last = !abort && (i == mw);
                push(last, 7'($urandom), 1'($urandom),
                     mk(1, st, 1, 0, last && ld, 2'd0, 0, 2'b00, 0, 0, last && st, 0, 0),
                     last && st);
            end
            if (abort || st) return;
        end
        // WB
        push_idle_like(mk(0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 1, ld, 1, 0, 0), 1);
    endtask

    // Entered and left at posedge+1: drive, queue expectation, compare at negedge
    task automatic run_plan();
        cyc_t c;
        cyc_t e;
        while (plan_q.size() > 0) begin
            c = plan_q.pop_front();
            mem_ack_i      = c.ack;
            mem_rdata_op_i = c.rdata;
            branch_taken_i = c.taken;
            sb_q.push_back(c);
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("cyc%0d outputs", cyc_idx), {17'd0, w_act}, {17'd0, e.exp});
            check($sformatf("cyc%0d instret", cyc_idx), {28'd0, instret_o}, {28'd0, e.cnt});
            cyc_idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mem_ack_i = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {17'd0, w_act}, 32'd0);
        check("reset instret", {28'd0, instret_o}, 32'd0);
        rst_n = 1'b1;
        m_cnt = 4'd0;
        // IDLE cycle right after release
        push_idle_like(15'd0, 0);
    endtask

    instr_t tbl[8];

    initial begin
        n_pass         = 0;
        n_total        = 0;
        cyc_idx        = 0;
        m_cnt          = 4'd0;
        rst_n          = 1'b0;
        mem_ack_i      = 1'b0;
        mem_rdata_op_i = 7'd0;
        branch_taken_i = 1'b0;

        tbl[0] = '{opc: c_OPIMM,  fw: 0, mw: 0, taken: 1'b0};
        tbl[1] = '{opc: c_LOAD,   fw: 2, mw: 2, taken: 1'b0};
        tbl[2] = '{opc: c_STORE,  fw: 0, mw: 0, taken: 1'b0};
        tbl[3] = '{opc: c_BRANCH, fw: 0, mw: 0, taken: 1'b1};
        tbl[4] = '{opc: c_BRANCH, fw: 1, mw: 0, taken: 1'b0};
        tbl[5] = '{opc: c_OP,     fw: 0, mw: 0, taken: 1'b0};
        tbl[6] = '{opc: c_STORE,  fw: 1, mw: 3, taken: 1'b0};
        tbl[7] = '{opc: c_LOAD,   fw: 0, mw: 0, taken: 1'b0};

        // Table of instructions with assorted wait states
        do_reset();
        foreach (tbl[i]) add_instr(tbl[i].opc, tbl[i].fw, tbl[i].mw, tbl[i].taken, 1'b0);
        run_plan();
        check("instret after table", {28'd0, instret_o}, 32'd8);

        // Reset asserted while a load waits in MEM
        add_instr(c_LOAD, 1, 2, 1'b0, 1'b1);
        run_plan();
        mem_ack_i = 1'b0;
        #1;
        check("mem_req held before reset", {31'd0, mem_req_o}, 32'd1);
        check("addr_sel held before reset", {31'd0, addr_sel_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset mem_req", {31'd0, mem_req_o}, 32'd0);
        check("async reset outputs", {17'd0, w_act}, 32'd0);
        check("async reset instret", {28'd0, instret_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cnt = 4'd0;
        push_idle_like(15'd0, 0);

        // Sixteen OPs wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) add_instr(c_OP, $urandom_range(0, 1), 0, 1'b0, 1'b0);
        run_plan();
        check("instret wrap", {28'd0, instret_o}, 32'd0);

        // Unsupported opcode: TRAP, sticky flag, no further requests
        add_instr(c_OPIMM, 0, 0, 1'b0, 1'b0);
        add_instr(c_BAD, 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            push_idle_like(mk(0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 0, 0, 0, 0, 1), 0);
        run_plan();
        check("trap illegal held", {31'd0, illegal_o}, 32'd1);
        check("trap instret frozen", {28'd0, instret_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
